// File: rtl/mem_lsu.sv
// Load/store unit for the MEM stage: decodes and checks one request at a time,
// runs a start/finish bus transaction and returns extended load data.
module mem_lsu #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [3:0]        req_ctrl,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              rd_start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_finish,
    input  logic [XLEN-1:0]   rd_data,
    output logic              wr_start,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [XLEN-1:0]   wr_data,
    output logic [XLEN/8-1:0] wr_strb,
    input  logic              wr_finish
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t            state_q, state_d;
    logic              rd_start_q, rd_start_d;
    logic              wr_start_q, wr_start_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [XLEN-1:0]   wr_data_q, wr_data_d;
    logic [NB-1:0]     wr_strb_q, wr_strb_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              sext_q, sext_d;

    // Request decode: size is log2 of the access width in bytes
    logic [1:0]        dec_size;
    logic              dec_sext;
    logic              dec_legal;
    logic [2:0]        dec_mask;
    logic              dec_misal;
    logic [OFF_W-1:0]  req_off;
    logic [ADDR_W-1:0] bus_addr;
    logic [XLEN-1:0]   st_mask;
    logic [XLEN-1:0]   st_data;
    logic [NB-1:0]     st_strb;

    always_comb begin
        dec_size  = 2'd0;
        dec_sext  = 1'b0;
        dec_legal = 1'b1;
        case (req_ctrl)
            4'b0000: begin dec_size = 2'd3; dec_legal = (XLEN == 64); end
            4'b0001: dec_size = 2'd1;
            4'b0010: dec_size = 2'd0;
            4'b0011: begin dec_size = 2'd2; dec_sext = 1'b1; end
            4'b0100: begin dec_size = 2'd1; dec_sext = 1'b1; end
            4'b0101: begin dec_size = 2'd2; dec_legal = (XLEN == 64); end
            4'b0110: begin dec_size = 2'd0; dec_sext = 1'b1; end
            4'b1000: begin dec_size = 2'd3; dec_legal = (XLEN == 64); end
            4'b1001: dec_size = 2'd2;
            4'b1010: dec_size = 2'd1;
            4'b1011: dec_size = 2'd0;
            default: dec_legal = 1'b0;
        endcase
        dec_mask  = (3'd1 << dec_size) - 3'd1;
        dec_misal = (req_addr[2:0] & dec_mask) != 3'd0;
        req_off   = req_addr[OFF_W-1:0];
        bus_addr  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        st_mask   = ~({XLEN{1'b1}} << (8 << dec_size));
        st_data   = (req_wdata & st_mask) << {req_off, 3'b000};
        st_strb   = (~({NB{1'b1}} << (1 << dec_size))) << req_off;
    end

    logic [XLEN-1:0]  ld_sh;
    logic [XLEN-1:0]  ld_mask;
    logic [IDX_W-1:0] ld_msb;
    logic [XLEN-1:0]  ld_val;

    always_comb begin
        ld_sh   = rd_data >> {off_q, 3'b000};
        ld_mask = ~({XLEN{1'b1}} << (8 << size_q));
        ld_msb  = IDX_W'((8 << size_q) - 1);
        ld_val  = (sext_q && ld_sh[ld_msb]) ? (ld_sh | ~ld_mask) : (ld_sh & ld_mask);
    end

    always_comb begin
        state_d      = state_q;
        rd_start_d   = rd_start_q;
        wr_start_d   = wr_start_q;
        rd_addr_d    = rd_addr_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_strb_d    = wr_strb_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        off_d        = off_q;
        size_d       = size_q;
        sext_d       = sext_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    off_d        = req_off;
                    size_d       = dec_size;
                    sext_d       = dec_sext;
                    resp_rdata_d = '0;
                    if (!dec_legal || dec_misal) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (req_ctrl[3]) begin
                        state_d    = WRITE;
                        wr_start_d = 1'b1;
                        wr_addr_d  = bus_addr;
                        wr_data_d  = st_data;
                        wr_strb_d  = st_strb;
                    end else begin
                        state_d    = READ;
                        rd_start_d = 1'b1;
                        rd_addr_d  = bus_addr;
                    end
                end
            end
            READ: begin
                if (rd_finish) begin
                    state_d      = RESP;
                    rd_start_d   = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = ld_val;
                end
            end
            WRITE: begin
                if (wr_finish) begin
                    state_d      = RESP;
                    wr_start_d   = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rd_start_q   <= 1'b0;
            wr_start_q   <= 1'b0;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_strb_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            off_q        <= '0;
            size_q       <= 2'd0;
            sext_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_start_q   <= rd_start_d;
            wr_start_q   <= wr_start_d;
            rd_addr_q    <= rd_addr_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_strb_q    <= wr_strb_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            off_q        <= off_d;
            size_q       <= size_d;
            sext_q       <= sext_d;
        end
    end

    // Ready is held low for the whole time reset is asserted
    assign req_ready  = (state_q == IDLE) && !rst;
    assign rd_start   = rd_start_q;
    assign wr_start   = wr_start_q;
    assign rd_addr    = rd_addr_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_strb    = wr_strb_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a 64-bit instance for the main sequences and a
// 32-bit instance for width-dependent legality.
module tb_mem_lsu;

    logic        clk;
    logic        rst;
    logic [63:0] req_addr;
    logic [3:0]  req_ctrl;

    logic        req_valid, req_ready, resp_valid, resp_ready, resp_err;
    logic [63:0] req_wdata, resp_rdata, rd_addr, rd_data, wr_addr, wr_data;
    logic        rd_start, rd_finish, wr_start, wr_finish;
    logic [7:0]  wr_strb;

    logic        req_valid32, req_ready32, resp_valid32, resp_ready32, resp_err32;
    logic [31:0] req_wdata32, resp_rdata32, rd_data32, wr_data32;
    logic [63:0] rd_addr32, wr_addr32;
    logic        rd_start32, rd_finish32, wr_start32, wr_finish32;
    logic [3:0]  wr_strb32;

    int checks = 0;
    int errors = 0;

    mem_lsu #(.XLEN(64), .ADDR_W(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ctrl(req_ctrl),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .rd_start(rd_start), .rd_addr(rd_addr), .rd_finish(rd_finish), .rd_data(rd_data),
        .wr_start(wr_start), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .wr_finish(wr_finish)
    );

    mem_lsu #(.XLEN(32), .ADDR_W(64)) dut32 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid32), .req_ready(req_ready32), .req_addr(req_addr),
        .req_wdata(req_wdata32), .req_ctrl(req_ctrl),
        .resp_valid(resp_valid32), .resp_ready(resp_ready32),
        .resp_rdata(resp_rdata32), .resp_err(resp_err32),
        .rd_start(rd_start32), .rd_addr(rd_addr32), .rd_finish(rd_finish32), .rd_data(rd_data32),
        .wr_start(wr_start32), .wr_addr(wr_addr32), .wr_data(wr_data32), .wr_strb(wr_strb32),
        .wr_finish(wr_finish32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 0; req_addr = '0; req_wdata = '0; req_ctrl = '0;
        resp_ready = 0; rd_finish = 0; rd_data = '0; wr_finish = 0;
        req_valid32 = 0; req_wdata32 = '0; resp_ready32 = 0;
        rd_finish32 = 0; rd_data32 = '0; wr_finish32 = 0;

        // reset state
        step(); step();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_rd_start", rd_start, 0);
        chk("rst_wr_start", wr_start, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_wr_strb", wr_strb, 0);
        chk("rst_rdata", resp_rdata, 0);
        rst = 1'b0;
        step();
        chk("post_rst_ready", req_ready, 1);

        // LW with sign extension, finish in first READ cycle
        req_valid = 1; req_addr = 64'h8000_0004; req_ctrl = 4'b0011;
        step();
        req_valid = 0; req_addr = 64'hDEAD_BEEF; req_ctrl = 4'b1111;
        chk("lw_rd_start", rd_start, 1);
        chk("lw_rd_addr", rd_addr, 64'h8000_0000);
        chk("lw_ready_low", req_ready, 0);
        chk("lw_no_resp_yet", resp_valid, 0);
        rd_finish = 1; rd_data = 64'h8765_4321_0000_0000;
        step();
        rd_finish = 0; rd_data = '0;
        chk("lw_resp_valid", resp_valid, 1);
        chk("lw_rd_start_low", rd_start, 0);
        chk("lw_rdata", resp_rdata, 64'hFFFF_FFFF_8765_4321);
        chk("lw_err", resp_err, 0);
        resp_ready = 1;
        step();
        resp_ready = 0;
        chk("lw_resp_done", resp_valid, 0);
        chk("lw_ready_again", req_ready, 1);

        // SB with 4-cycle write latency; stray rd_finish must be ignored
        req_valid = 1; req_addr = 64'h8000_0003; req_wdata = 64'h1234_56AB; req_ctrl = 4'b1011;
        step();
        req_valid = 0; req_wdata = '1;
        chk("sb_wr_start", wr_start, 1);
        chk("sb_wr_addr", wr_addr, 64'h8000_0000);
        chk("sb_wr_strb", wr_strb, 8'h08);
        chk("sb_wr_data", wr_data, 64'h0000_0000_AB00_0000);
        rd_finish = 1;
        step();
        rd_finish = 0;
        chk("sb_hold1", wr_start, 1);
        chk("sb_no_rd", rd_start, 0);
        chk("sb_no_resp", resp_valid, 0);
        step();
        chk("sb_hold2", wr_start, 1);
        chk("sb_data_stable", wr_data, 64'h0000_0000_AB00_0000);
        step();
        chk("sb_hold3", wr_start, 1);
        wr_finish = 1;
        step();
        wr_finish = 0;
        chk("sb_resp_valid", resp_valid, 1);
        chk("sb_wr_start_low", wr_start, 0);
        chk("sb_rdata", resp_rdata, 0);
        chk("sb_err", resp_err, 0);
        resp_ready = 1;
        step();
        resp_ready = 0;

        // misaligned LH: error after one cycle, no bus traffic
        req_valid = 1; req_addr = 64'h8000_0001; req_ctrl = 4'b0100;
        step();
        req_valid = 0;
        chk("lh_mis_valid", resp_valid, 1);
        chk("lh_mis_err", resp_err, 1);
        chk("lh_mis_rd", rd_start, 0);
        chk("lh_mis_wr", wr_start, 0);
        chk("lh_mis_rdata", resp_rdata, 0);
        resp_ready = 1;
        step();
        resp_ready = 0;

        // illegal opcode 0111
        req_valid = 1; req_addr = 64'h40; req_ctrl = 4'b0111;
        step();
        req_valid = 0;
        chk("ill_valid", resp_valid, 1);
        chk("ill_err", resp_err, 1);
        chk("ill_bus", {rd_start, wr_start}, 0);
        resp_ready = 1;
        step();
        resp_ready = 0;

        // LD is illegal on the 32-bit instance
        req_valid32 = 1; req_addr = 64'h0; req_ctrl = 4'b0000;
        step();
        req_valid32 = 0;
        chk("ld32_valid", resp_valid32, 1);
        chk("ld32_err", resp_err32, 1);
        chk("ld32_bus", {rd_start32, wr_start32}, 0);
        resp_ready32 = 1;
        step();
        resp_ready32 = 0;

        // SH on the 32-bit instance at offset 2
        req_valid32 = 1; req_addr = 64'h2; req_ctrl = 4'b1010; req_wdata32 = 32'h5555_BEEF;
        step();
        req_valid32 = 0;
        chk("sh32_wr_start", wr_start32, 1);
        chk("sh32_wr_addr", wr_addr32, 64'h0);
        chk("sh32_wr_strb", wr_strb32, 4'b1100);
        chk("sh32_wr_data", wr_data32, 32'hBEEF_0000);
        wr_finish32 = 1;
        step();
        wr_finish32 = 0;
        chk("sh32_resp", {resp_valid32, resp_err32}, 2'b10);
        resp_ready32 = 1;
        step();
        resp_ready32 = 0;

        // LBU with response backpressure
        req_valid = 1; req_addr = 64'h10; req_ctrl = 4'b0010;
        step();
        req_valid = 0;
        chk("lbu_rd_addr", rd_addr, 64'h10);
        rd_finish = 1; rd_data = 64'hFFFF_FFFF_FFFF_FF80;
        step();
        rd_finish = 0; rd_data = 64'h1111_1111_1111_1111;
        for (int i = 0; i < 3; i++) begin
            chk("lbu_hold_valid", resp_valid, 1);
            chk("lbu_hold_rdata", resp_rdata, 64'h80);
            chk("lbu_hold_ready", req_ready, 0);
            step();
        end
        resp_ready = 1;
        step();
        resp_ready = 0;
        chk("lbu_done", resp_valid, 0);
        chk("lbu_ready_again", req_ready, 1);

        // LB at offset 5, sign extended
        req_valid = 1; req_addr = 64'h35; req_ctrl = 4'b0110;
        step();
        req_valid = 0;
        chk("lb_rd_addr", rd_addr, 64'h30);
        rd_finish = 1; rd_data = 64'h0000_F000_0000_0000;
        step();
        rd_finish = 0;
        chk("lb_rdata", resp_rdata, 64'hFFFF_FFFF_FFFF_FFF0);
        resp_ready = 1;
        step();
        resp_ready = 0;

        // reset in the middle of a READ
        req_valid = 1; req_addr = 64'h20; req_ctrl = 4'b0000;
        step();
        req_valid = 0;
        chk("mid_rd_start", rd_start, 1);
        rst = 1;
        #1;
        chk("mid_rst_rd_start", rd_start, 0);
        chk("mid_rst_ready", req_ready, 0);
        step();
        rst = 0;
        rd_finish = 1; rd_data = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        rd_finish = 0;
        chk("mid_rst_no_resp", resp_valid, 0);
        chk("mid_rst_idle", req_ready, 1);

        // LD completes normally afterwards
        req_valid = 1; req_addr = 64'h28; req_ctrl = 4'b0000;
        step();
        req_valid = 0;
        chk("ld_rd_addr", rd_addr, 64'h28);
        rd_finish = 1; rd_data = 64'h0123_4567_89AB_CDEF;
        step();
        rd_finish = 0;
        chk("ld_resp", {resp_valid, resp_err}, 2'b10);
        chk("ld_rdata", resp_rdata, 64'h0123_4567_89AB_CDEF);
        resp_ready = 1;
        step();
        resp_ready = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Parametrised load/store unit for the MEM stage of the core: accepts one load or store per request handshake, performs address alignment checks, drives the start/finish bus interface toward the AXI4 adapter, and returns naturally aligned, zero- or sign-extended load data. It adds width generalisation, byte-lane write strobes, misalignment/illegal-op error reporting and a valid/ready front end with response backpressure.

## Interface
Parameters:
- XLEN, 64, data width in bits; 32 or 64. Bus word is XLEN/8 bytes.
- ADDR_W, 64, address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- req_ctrl  in  4  operation code; see Operation.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes response.
- resp_rdata  out  XLEN  load result; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal request.
- rd_start  out  1  bus read request, held until rd_finish.
- rd_addr  out  ADDR_W  bus-word-aligned read address.
- rd_finish  in  1  read done; rd_data valid this cycle.
- rd_data  in  XLEN  bus read word.
- wr_start  out  1  bus write request, held until wr_finish.
- wr_addr  out  ADDR_W  bus-word-aligned write address.
- wr_data  out  XLEN  lane-shifted store data.
- wr_strb  out  XLEN/8  byte-lane enables.
- wr_finish  in  1  write done.

## Operation
- req_ctrl codes: 0000 LD (8B), 0001 LHU, 0010 LBU, 0011 LW (sext), 0100 LH (sext), 0101 LWU, 0110 LB (sext); 1000 SD, 1001 SW, 1010 SH, 1011 SB. Any other code is illegal; LD/LWU/SD are illegal when XLEN=32.
- Access size S bytes; misaligned when req_addr mod S != 0.
- off = req_addr[log2(XLEN/8)-1:0]; bus address = req_addr with those bits cleared.
- Store: wr_data = req_wdata << (8*off), unused lanes 0; wr_strb = ((1<<S)-1) << off.
- Load: result = (rd_data >> 8*off) truncated to S bytes, then zero- or sign-extended to XLEN per code.
- Request fields latched on accept (req_valid && req_ready); later input changes have no effect.
- FSM states: IDLE, READ, WRITE, RESP.
  - IDLE: on accept, go RESP with err=1 if illegal or misaligned (no bus activity); otherwise READ for loads, WRITE for stores.
  - READ: rd_start=1; on rd_finish capture the extracted load result and go RESP.
  - WRITE: wr_start=1; on wr_finish go RESP.
  - RESP: resp_valid=1; on resp_ready go IDLE.
- rd_finish/wr_finish ignored in any state other than READ/WRITE respectively; wr_finish in READ and rd_finish in WRITE are ignored.
- rd_addr/wr_addr/wr_data/wr_strb are registered and stable from the cycle the corresponding start rises until finish.

## Timing
- Reset (async assert): state=IDLE; req_ready=0 while rst high, 1 from the first cycle after deassertion; resp_valid, resp_err, rd_start, wr_start=0; resp_rdata, rd_addr, wr_addr, wr_data, wr_strb=0.
- Reset mid-transaction abandons it; no response is produced; bus adapter is reset by the same rst.
- Accept at edge T: rd_start/wr_start high in cycle T+1.
- Finish sampled at edge T+n: start low and resp_valid high in cycle T+n+1. Minimum accept-to-resp_valid latency 2 cycles; error path 1 cycle.
- resp_valid, resp_rdata, resp_err hold stable while resp_ready is low.
- req_ready goes high in the cycle after the response handshake, so back-to-back requests issue at most every 3 cycles.

## Test plan
- XLEN=64, LW addr 0x8000_0004, rd_data 0x8765_4321_0000_0000, rd_finish in first READ cycle -> rd_addr 0x8000_0000; resp_rdata 0xFFFF_FFFF_8765_4321, resp_err 0, resp_valid 2 cycles after accept.
- SB addr 0x8000_0003, wdata 0x1234_56AB -> wr_addr 0x8000_0000, wr_strb 0x08, wr_data 0x0000_0000_AB00_0000; wr_start held through 4-cycle wr_finish delay; resp_rdata 0.
- LH addr 0x8000_0001 -> no rd_start or wr_start; resp_valid with resp_err 1 one cycle after accept.
- req_ctrl 0111, and LD with XLEN=32 -> resp_err 1, no bus activity.
- LBU addr 0x10 with rd_data byte 0 0x80, resp_ready low for 3 cycles -> resp_rdata 0x80 stable, resp_valid held, req_ready 0 until handshake completes.
- rst asserted mid-READ -> rd_start 0 immediately; later rd_finish ignored; next LD completes normally.
